// File: rtl/lock_attempt_controller_pkg.sv
// Shared types and default constants for the lock attempt controller slice.
package lock_pkg;

    localparam int unsigned DEF_MAX_FAILS      = 3;
    localparam int unsigned DEF_OPEN_CYCLES    = 200;
    localparam int unsigned DEF_LOCKOUT_CYCLES = 1000;
    localparam int unsigned DEF_TMR_W          = 16;

    // Legacy state encodings, kept so existing tooling/scripts still match.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_OPEN    = 2'd1;
    localparam logic [1:0] ST_LOCKOUT = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        OPEN    = ST_OPEN,
        LOCKOUT = ST_LOCKOUT
    } lock_state_t;

endpackage

// File: rtl/lock_attempt_controller_if.sv
// Attempt handshake between the keypad/comparator front end and the controller.
interface lock_attempt_controller_if;

    logic attempt_valid;
    logic unlock_in;
    logic alarm_in;
    logic ready;

    modport master (
        output attempt_valid,
        output unlock_in,
        output alarm_in,
        input  ready
    );

    modport slave (
        input  attempt_valid,
        input  unlock_in,
        input  alarm_in,
        output ready
    );

endinterface

// File: rtl/lock_attempt_controller_timer.sv
// Loadable saturating down-counter shared by the OPEN and LOCKOUT windows.
module lock_timer #(
    parameter int unsigned TMR_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    input  logic             clear,
    output logic             expire
);

    logic [TMR_W-1:0] count_q;
    logic [TMR_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = (count_q == TMR_W'(1));

endmodule

// File: rtl/lock_attempt_controller.sv
// Turns comparator verdicts into solenoid-open windows, failure counting and
// timed lockout; attempts are only accepted while idle (ready high).
module lock_attempt_controller
    import lock_pkg::*;
#(
    parameter int unsigned MAX_FAILS      = DEF_MAX_FAILS,
    parameter int unsigned OPEN_CYCLES    = DEF_OPEN_CYCLES,
    parameter int unsigned LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
    parameter int unsigned TMR_W          = DEF_TMR_W
) (
    input  logic                      clk,
    input  logic                      reset,
    lock_attempt_controller_if.slave  att,
    input  logic                      admin_clear,
    output logic                      solenoid,
    output logic                      locked_out,
    output logic                      alarm_out,
    output logic [3:0]                fail_count
);

    lock_state_t      state_q, state_d;
    logic [3:0]       fail_count_q, fail_count_d;
    logic             ready_q, ready_d;
    logic             solenoid_q, solenoid_d;
    logic             locked_out_q, locked_out_d;
    logic             alarm_q, alarm_d;

    logic             accept;
    logic             fail_pulse;
    logic [4:0]       fail_inc;
    logic             lockout_hit;
    logic             tmr_load;
    logic             tmr_clear;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_expire;

    lock_timer #(
        .TMR_W(TMR_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .clear    (tmr_clear),
        .expire   (tmr_expire)
    );

    assign accept      = att.attempt_valid & ready_q;
    assign fail_inc    = {1'b0, fail_count_q} + 5'd1;
    // >= rather than == so the count saturates instead of ever passing MAX_FAILS.
    assign lockout_hit = (fail_inc >= 5'(MAX_FAILS));

    always_comb begin
        state_d      = state_q;
        fail_count_d = fail_count_q;
        tmr_load     = 1'b0;
        tmr_clear    = 1'b0;
        tmr_val      = '0;
        fail_pulse   = 1'b0;

        case (state_q)
            IDLE: begin
                if (admin_clear) begin
                    fail_count_d = '0;
                end else if (accept && att.alarm_in) begin
                    if (lockout_hit) begin
                        state_d      = LOCKOUT;
                        tmr_load     = 1'b1;
                        tmr_val      = TMR_W'(LOCKOUT_CYCLES);
                        fail_count_d = 4'(MAX_FAILS);
                    end else begin
                        fail_count_d = fail_inc[3:0];
                        fail_pulse   = 1'b1;
                    end
                end else if (accept && att.unlock_in) begin
                    state_d      = OPEN;
                    tmr_load     = 1'b1;
                    tmr_val      = TMR_W'(OPEN_CYCLES);
                    fail_count_d = '0;
                end
            end
            OPEN: begin
                if (admin_clear) begin
                    fail_count_d = '0;
                end
                if (tmr_expire) begin
                    state_d = IDLE;
                end
            end
            LOCKOUT: begin
                if (admin_clear) begin
                    state_d      = IDLE;
                    fail_count_d = '0;
                    tmr_clear    = 1'b1;
                end else if (tmr_expire) begin
                    state_d      = IDLE;
                    fail_count_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they register alongside it.
        ready_d      = (state_d == IDLE);
        solenoid_d   = (state_d == OPEN);
        locked_out_d = (state_d == LOCKOUT);
        alarm_d      = fail_pulse | locked_out_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            fail_count_q <= '0;
            ready_q      <= 1'b1;
            solenoid_q   <= 1'b0;
            locked_out_q <= 1'b0;
            alarm_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            fail_count_q <= fail_count_d;
            ready_q      <= ready_d;
            solenoid_q   <= solenoid_d;
            locked_out_q <= locked_out_d;
            alarm_q      <= alarm_d;
        end
    end

    assign att.ready  = ready_q;
    assign solenoid   = solenoid_q;
    assign locked_out = locked_out_q;
    assign alarm_out  = alarm_q;
    assign fail_count = fail_count_q;

endmodule

// File: tb/tb_lock_attempt_controller.sv
// Directed bench for lock_attempt_controller with MAX_FAILS=3, OPEN=4, LOCKOUT=8.
module tb_lock_attempt_controller;

    logic       clk;
    logic       reset;
    logic       admin_clear;
    logic       solenoid;
    logic       locked_out;
    logic       alarm_out;
    logic [3:0] fail_count;

    int nchecks = 0;
    int nerr    = 0;

    lock_attempt_controller_if att_if ();

    lock_attempt_controller #(
        .MAX_FAILS      (3),
        .OPEN_CYCLES    (4),
        .LOCKOUT_CYCLES (8),
        .TMR_W          (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .att         (att_if.slave),
        .admin_clear (admin_clear),
        .solenoid    (solenoid),
        .locked_out  (locked_out),
        .alarm_out   (alarm_out),
        .fail_count  (fail_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic v, input logic unl, input logic alm);
        att_if.attempt_valid = v;
        att_if.unlock_in     = unl;
        att_if.alarm_in      = alm;
    endtask

    task automatic check_idle(input string tag, input logic [3:0] fc);
        check({tag, "_ready"},    16'(att_if.ready), 16'd1);
        check({tag, "_solenoid"}, 16'(solenoid),     16'd0);
        check({tag, "_locked"},   16'(locked_out),   16'd0);
        check({tag, "_alarm"},    16'(alarm_out),    16'd0);
        check({tag, "_fails"},    16'(fail_count),   16'(fc));
    endtask

    initial begin
        reset       = 1'b1;
        admin_clear = 1'b0;
        strobe(1'b0, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        check_idle("reset", 4'd0);

        // Success: solenoid high and ready low for exactly 4 cycles.
        strobe(1'b1, 1'b1, 1'b0);
        tick();
        strobe(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("open_solenoid", 16'(solenoid),     16'd1);
            check("open_ready",    16'(att_if.ready), 16'd0);
            check("open_fails",    16'(fail_count),   16'd0);
            tick();
        end
        check_idle("after_open", 4'd0);

        // Two back-to-back failures, then a success.
        strobe(1'b1, 1'b0, 1'b1);
        tick();
        check("f1_alarm", 16'(alarm_out),  16'd1);
        check("f1_fails", 16'(fail_count), 16'd1);
        tick();
        strobe(1'b0, 1'b0, 1'b0);
        check("f2_alarm", 16'(alarm_out),  16'd1);
        check("f2_fails", 16'(fail_count), 16'd2);
        tick();
        check_idle("f2_settle", 4'd2);
        strobe(1'b1, 1'b1, 1'b0);
        tick();
        strobe(1'b0, 1'b0, 1'b0);
        check("succ_solenoid", 16'(solenoid),   16'd1);
        check("succ_fails",    16'(fail_count), 16'd0);
        check("succ_locked",   16'(locked_out), 16'd0);
        for (int i = 0; i < 4; i++) tick();
        check_idle("succ_done", 4'd0);

        // Three failures: 8-cycle lockout, strobes ignored meanwhile.
        strobe(1'b1, 1'b0, 1'b1);
        tick();
        tick();
        tick();
        strobe(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            check("lock_locked",   16'(locked_out),   16'd1);
            check("lock_alarm",    16'(alarm_out),    16'd1);
            check("lock_ready",    16'(att_if.ready), 16'd0);
            check("lock_solenoid", 16'(solenoid),     16'd0);
            check("lock_fails",    16'(fail_count),   16'd3);
            tick();
        end
        strobe(1'b0, 1'b0, 1'b0);
        check_idle("lock_done", 4'd0);

        // Conflicting verdict counts as a failure.
        strobe(1'b1, 1'b1, 1'b1);
        tick();
        strobe(1'b0, 1'b0, 1'b0);
        check("conf_fails",    16'(fail_count), 16'd1);
        check("conf_solenoid", 16'(solenoid),   16'd0);
        check("conf_alarm",    16'(alarm_out),  16'd1);

        // Two more failures reach lockout; admin_clear on lockout cycle 3.
        strobe(1'b1, 1'b0, 1'b1);
        tick();
        check("pre_lock_fails", 16'(fail_count), 16'd2);
        tick();
        strobe(1'b0, 1'b0, 1'b0);
        check("adm_lock_entered", 16'(locked_out), 16'd1);
        tick();
        tick();
        admin_clear = 1'b1;
        tick();
        admin_clear = 1'b0;
        check_idle("adm_lockout", 4'd0);

        // admin_clear beats a same-cycle attempt in IDLE.
        strobe(1'b1, 1'b0, 1'b1);
        tick();
        check("adm_pre_fails", 16'(fail_count), 16'd1);
        admin_clear = 1'b1;
        tick();
        check_idle("adm_drop_fail", 4'd0);
        strobe(1'b1, 1'b1, 1'b0);
        tick();
        admin_clear = 1'b0;
        strobe(1'b0, 1'b0, 1'b0);
        check_idle("adm_drop_succ", 4'd0);

        // Asynchronous reset mid-OPEN.
        strobe(1'b1, 1'b1, 1'b0);
        tick();
        strobe(1'b0, 1'b0, 1'b0);
        tick();
        check("rst_open_solenoid", 16'(solenoid), 16'd1);
        reset = 1'b1;
        #1;
        check("rst_async_solenoid", 16'(solenoid),     16'd0);
        check("rst_async_ready",    16'(att_if.ready), 16'd1);
        tick();
        reset = 1'b0;
        tick();
        check_idle("rst_release", 4'd0);
        tick();
        tick();
        check_idle("rst_settled", 4'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
